// File: rtl/adder_tree_feeder.sv
// Serial-to-parallel packer feeding adder_tree with NUM_INPUTS words per bundle.
// Optional early frame close via s_last when ADDER_FEEDER_FLUSH_EN is defined.
module adder_tree_feeder #(
    parameter int DATAWIDTH  = 4,
    parameter int NUM_INPUTS = 16,
    parameter int CNT_W      = 16,
    localparam int LANE_W    = $clog2(NUM_INPUTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATAWIDTH-1:0]            s_data,
    input  logic                            s_last,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_INPUTS*DATAWIDTH-1:0] m_data,
    output logic [LANE_W-1:0]               o_lane,
    output logic [CNT_W-1:0]                o_frames
);

    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [LANE_W-1:0] LAST = LANE_W'(NUM_INPUTS - 1);

    state_t                            state_q;
    state_t                            state_d;
    logic [LANE_W-1:0]                 lane;
    logic [NUM_INPUTS*DATAWIDTH-1:0]   fill;
    logic [NUM_INPUTS*DATAWIDTH-1:0]   merged;
    logic                              closing_lane;
    logic                              out_free;
    logic                              accept;
    logic                              close;

`ifdef ADDER_FEEDER_FLUSH_EN
    assign closing_lane = (lane == LAST) || s_last;
`else
    logic unused_last;
    assign unused_last  = s_last;
    assign closing_lane = (lane == LAST);
`endif

    // The output slot can take a new bundle when empty or draining this cycle.
    assign out_free = !m_valid || m_ready;
    assign s_ready  = closing_lane ? out_free : 1'b1;
    assign accept   = s_valid && s_ready;
    assign close    = accept && closing_lane;
    assign m_valid  = (state_q == FULL);
    assign o_lane   = lane;

    // Fill buffer with the incoming word dropped into the current lane.
    always_comb begin
        merged = fill;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (lane == LANE_W'(k)) begin
                merged[k*DATAWIDTH +: DATAWIDTH] = s_data;
            end
        end
    end

    // Lane pointer and fill buffer; both restart when a frame closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane <= '0;
            fill <= '0;
        end else if (accept) begin
            if (close) begin
                lane <= '0;
                fill <= '0;
            end else begin
                lane <= lane + LANE_W'(1);
                fill <= merged;
            end
        end
    end

    // Output register loads only on frame close, so it holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data <= '0;
        end else if (close) begin
            m_data <= merged;
        end
    end

    // Output state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output next-state: fill on close, drain on downstream accept.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (close) state_d = FULL;
            end
            FULL: begin
                if (m_ready) state_d = close ? FULL : EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Count bundles handed downstream, wrapping silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_frames <= '0;
        end else if (m_valid && m_ready) begin
            o_frames <= o_frames + CNT_W'(1);
        end
    end

endmodule
